// File: rtl/psum_accum_sfu_pkg.sv
// Shared constants for the psum accumulator SFU.
// FSM encodings and default array dimensions.
package psum_accum_sfu_pkg;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 16;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
endpackage

// File: rtl/psum_accum_sfu_sat_relu.sv
// Saturating psum add plus optional ReLU.
// Pure combinational, shared by every SFU lane.
module sat_relu #(
  parameter int psum_bw = 16
) (
  input  logic signed [psum_bw-1:0] acc,
  input  logic signed [psum_bw-1:0] psum,
  input  logic                      first,
  input  logic                      relu_en,
  output logic signed [psum_bw-1:0] sum,
  output logic signed [psum_bw-1:0] res,
  output logic                      sat
);
  localparam logic signed [psum_bw-1:0] maxv =
    {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] minv =
    {1'b1, {(psum_bw-1){1'b0}}};

  logic signed [psum_bw-1:0] base;
  logic signed [psum_bw:0]   wide;
  logic                      hi;
  logic                      lo;

  assign base = first ? '0 : acc;
  assign wide = {base[psum_bw-1], base}
              + {psum[psum_bw-1], psum};
  // Top two bits disagree only when the result left the range.
  assign hi  = (wide[psum_bw:psum_bw-1] == 2'b01);
  assign lo  = (wide[psum_bw:psum_bw-1] == 2'b10);
  assign sat = hi || lo;

  always_comb begin
    sum = wide[psum_bw-1:0];
    if (hi) sum = maxv;
    if (lo) sum = minv;
  end

  assign res = (relu_en && sum[psum_bw-1]) ? '0 : sum;
endmodule

// File: rtl/psum_accum_sfu.sv
// Per-channel psum accumulator with ReLU emit,
// saturation flag and a one-entry-per-cycle clear sweep.
module psum_accum_sfu
  import psum_accum_sfu_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH,
  parameter int addr_bw = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [psum_bw-1:0] in_psum,
  input  logic [addr_bw-1:0]        in_addr,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      relu_en,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [psum_bw-1:0] out_data,
  output logic [addr_bw-1:0]        out_addr,
  output logic                      ovf
);
  localparam logic [addr_bw-1:0] cnt_end =
    addr_bw'(depth - 1);

  logic [0:0]                state;
  logic [addr_bw-1:0]        cnt;
  logic signed [psum_bw-1:0] mem [depth];

  logic                      addr_ok;
  logic                      accept;
  logic                      wr;
  logic                      sat;
  logic signed [psum_bw-1:0] acc;
  logic signed [psum_bw-1:0] sum;
  logic signed [psum_bw-1:0] res;

  assign addr_ok  = 32'(in_addr) < depth;
  assign in_ready = (state == RUN)
                 && !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  // Out-of-range beats are swallowed: no write, no emit.
  assign wr       = accept && addr_ok;
  assign acc      = addr_ok ? mem[in_addr] : '0;

  sat_relu #(
    .psum_bw(psum_bw)
  ) u_sat_relu (
    .acc    (acc),
    .psum   (in_psum),
    .first  (in_first),
    .relu_en(relu_en),
    .sum    (sum),
    .res    (res),
    .sat    (sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          if (wr) mem[in_addr] <= sum;
          if (wr && sat) ovf <= 1'b1;
          if (clear) begin
            state <= CLEAR;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == cnt_end) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (wr && in_last) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_addr  <= in_addr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psum_accum_sfu.sv
// Directed bench for psum_accum_sfu.
// Inputs change on negedge, outputs sampled on negedge.
module tb_psum_accum_sfu;
  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_psum;
  logic [3:0]         in_addr;
  logic               in_first;
  logic               in_last;
  logic               relu_en;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [3:0]         out_addr;
  logic               ovf;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  psum_accum_sfu dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_psum  (in_psum),
    .in_addr  (in_addr),
    .in_first (in_first),
    .in_last  (in_last),
    .relu_en  (relu_en),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .ovf      (ovf)
  );

  task automatic send(input logic [3:0] a,
                      input logic signed [15:0] p,
                      input logic f, input logic l,
                      input logic r);
    in_valid = 1'b1;
    in_addr  = a;
    in_psum  = p;
    in_first = f;
    in_last  = l;
    relu_en  = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    ncmp++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0
        || out_addr !== 4'd0 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outs: v=%b d=%0d a=%0d o=%b want 0",
               out_valid, out_data, out_addr, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    ncmp++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_multi_tile;
    send(4'd3, 16'sd100, 1'b1, 1'b0, 1'b1);
    send(4'd3, -16'sd30, 1'b0, 1'b0, 1'b1);
    send(4'd3, 16'sd5, 1'b0, 1'b1, 1'b1);
    ncmp++;
    if (out_valid !== 1'b1 || out_data !== 16'sd75
        || out_addr !== 4'd3) begin
      nerr++;
      $display("FAIL multi_tile: v=%b d=%0d a=%0d want 1/75/3",
               out_valid, out_data, out_addr);
    end
    idle(1);
    ncmp++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL multi_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_relu;
    send(4'd1, -16'sd50, 1'b1, 1'b1, 1'b1);
    ncmp++;
    if (out_data !== 16'sd0 || out_addr !== 4'd1) begin
      nerr++;
      $display("FAIL relu_zero: d=%0d a=%0d want 0/1",
               out_data, out_addr);
    end
    send(4'd1, 16'sd0, 1'b0, 1'b1, 1'b0);
    ncmp++;
    if (out_data !== -16'sd50) begin
      nerr++;
      $display("FAIL relu_store: got %0d want -50", out_data);
    end
    send(4'd1, -16'sd50, 1'b1, 1'b1, 1'b0);
    ncmp++;
    if (out_data !== -16'sd50) begin
      nerr++;
      $display("FAIL relu_off: got %0d want -50", out_data);
    end
    idle(1);
  endtask

  task automatic test_saturation;
    send(4'd0, 16'sd32000, 1'b1, 1'b0, 1'b0);
    send(4'd0, 16'sd1000, 1'b0, 1'b1, 1'b0);
    ncmp++;
    if (out_data !== 16'sd32767 || ovf !== 1'b1) begin
      nerr++;
      $display("FAIL sat_pos: d=%0d o=%b want 32767/1",
               out_data, ovf);
    end
    send(4'd5, -16'sd32000, 1'b1, 1'b0, 1'b0);
    send(4'd5, -16'sd1000, 1'b0, 1'b1, 1'b0);
    ncmp++;
    if (out_data !== -16'sd32768) begin
      nerr++;
      $display("FAIL sat_neg: got %0d want -32768", out_data);
    end
    idle(1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ncmp++;
    if (ovf !== 1'b0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL clear_enter: o=%b r=%b want 0/0",
               ovf, in_ready);
    end
    repeat (15) @(negedge clk);
    ncmp++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL clear_len: ready=%b want 0", in_ready);
    end
    @(negedge clk);
    ncmp++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL clear_done: ready=%b want 1", in_ready);
    end
    send(4'd0, 16'sd0, 1'b0, 1'b1, 1'b0);
    ncmp++;
    if (out_data !== 16'sd0 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL clear_mem0: d=%0d v=%b want 0/1",
               out_data, out_valid);
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(4'd4, 16'sd7, 1'b1, 1'b1, 1'b0);
    in_addr  = 4'd6;
    in_psum  = -16'sd9;
    #1;
    ncmp++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    ncmp++;
    if (out_valid !== 1'b1 || out_data !== 16'sd7
        || out_addr !== 4'd4) begin
      nerr++;
      $display("FAIL bp_hold: v=%b d=%0d a=%0d want 1/7/4",
               out_valid, out_data, out_addr);
    end
    out_ready = 1'b1;
    @(negedge clk);
    ncmp++;
    if (out_valid !== 1'b1 || out_data !== -16'sd9
        || out_addr !== 4'd6) begin
      nerr++;
      $display("FAIL bp_second: v=%b d=%0d a=%0d want 1/-9/6",
               out_valid, out_data, out_addr);
    end
    idle(1);
    ncmp++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    send(4'd2, 16'sd10, 1'b1, 1'b0, 1'b0);
    send(4'd2, 16'sd20, 1'b0, 1'b0, 1'b0);
    send(4'd2, 16'sd30, 1'b0, 1'b1, 1'b0);
    ncmp++;
    if (out_data !== 16'sd60 || out_addr !== 4'd2) begin
      nerr++;
      $display("FAIL b2b: d=%0d a=%0d want 60/2",
               out_data, out_addr);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_clear;
    send(4'd7, 16'sd123, 1'b1, 1'b0, 1'b0);
    send(4'd0, 16'sd32767, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(4'd8, 16'sd55, 1'b1, 1'b1, 1'b0);
    idle(0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    ncmp++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0
        || out_addr !== 4'd0 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL rmc_outs: v=%b d=%0d a=%0d o=%b want 0",
               out_valid, out_data, out_addr, ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ncmp++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rmc_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 16'sd0, 1'b0, 1'b1, 1'b0);
      ncmp++;
      if (out_valid !== 1'b1 || out_data !== 16'sd0
          || out_addr !== 4'(i)) begin
        nerr++;
        $display("FAIL rmc_mem%0d: v=%b d=%0d a=%0d want 1/0/%0d",
                 i, out_valid, out_data, out_addr, i);
      end
    end
    idle(1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_psum   = '0;
    in_addr   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    relu_en   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset;
    test_multi_tile;
    test_relu;
    test_saturation;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
